// File: rtl/sonar_varredura_if.sv
// Result hand-off bundle between the sweeping sonar and a downstream serial transmitter.
// The producer holds dado_* stable while dado_valido is high until dado_pronto is sampled.
interface sonar_varredura_if #(
    parameter int unsigned POS_W  = 3,
    parameter int unsigned DIST_W = 9
);
    logic              dado_valido;
    logic              dado_pronto;
    logic [POS_W-1:0]  dado_posicao;
    logic [DIST_W-1:0] dado_distancia;
    logic              dado_timeout;

    modport master (
        output dado_valido,
        output dado_posicao,
        output dado_distancia,
        output dado_timeout,
        input  dado_pronto
    );

    modport slave (
        input  dado_valido,
        input  dado_posicao,
        input  dado_distancia,
        input  dado_timeout,
        output dado_pronto
    );
endinterface

// File: rtl/sonar_varredura.sv
// Sweeping sonar controller: servo PWM over N_POS positions, one ultrasonic ranging per
// position, results handed off over a valid/ready bundle. Ping-pong or single-sweep mode.
module sonar_varredura #(
    parameter int unsigned N_POS       = 8,
    parameter int unsigned PWM_PERIOD  = 1000000,
    parameter int unsigned PWM_MIN     = 50000,
    parameter int unsigned PWM_MAX     = 100000,
    parameter int unsigned SETTLE_CYC  = 25000000,
    parameter int unsigned TRIG_CYC    = 500,
    parameter int unsigned CYC_PER_CM  = 2941,
    parameter int unsigned TIMEOUT_CYC = 1500000,
    parameter int unsigned DIST_W      = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ligar,
    input  logic                modo,
    input  logic                echo,
    output logic                trigger,
    output logic                pwm,
    sonar_varredura_if.master   dado,
    output logic                fim_posicao,
    output logic                fim_varredura,
    output logic [3:0]          db_estado
);

    localparam int unsigned POS_W   = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int unsigned STEP    = (PWM_MAX - PWM_MIN) / (N_POS - 1);
    localparam int unsigned PWM_TOP = (PWM_PERIOD > PWM_MAX) ? PWM_PERIOD : PWM_MAX + 1;
    localparam int unsigned PW      = $clog2(PWM_TOP + 1);
    localparam int unsigned CNT_A   = (SETTLE_CYC > TRIG_CYC) ? SETTLE_CYC : TRIG_CYC;
    localparam int unsigned CNT_TOP = (CNT_A > TIMEOUT_CYC) ? CNT_A : TIMEOUT_CYC;
    localparam int unsigned CW      = $clog2(CNT_TOP + 1);
    localparam int unsigned SW      = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [PW-1:0]     PWM_LAST    = PW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]     TRIG_LAST   = CW'(TRIG_CYC - 1);
    localparam logic [CW-1:0]     TO_LAST     = CW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0]     SUB_LAST    = SW'(CYC_PER_CM - 1);
    localparam logic [POS_W-1:0]  POS_LAST    = POS_W'(N_POS - 1);
    localparam logic [DIST_W-1:0] DIST_MAX    = '1;

    typedef enum logic [2:0] {
        StInicial    = 3'd0,
        StPosiciona  = 3'd1,
        StDispara    = 3'd2,
        StEsperaEcho = 3'd3,
        StMede       = 3'd4,
        StEnvia      = 3'd5,
        StProxima    = 3'd6,
        StFim        = 3'd7
    } estado_e;

    estado_e           estado_q, estado_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     sub_q, sub_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              to_q, to_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              desce_q, desce_d;
    logic              modo_q, modo_d;
    logic [PW-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [PW-1:0]     pwm_larg_q, pwm_larg_d;
    logic [PW-1:0]     larg_alvo;
    logic              echo_s1_q, echo_s2_q;
    logic [SW-1:0]     sub_base, sub_inc;
    logic [DIST_W-1:0] dist_base, dist_inc;
    logic              valido;

    // Servo PWM: new width is only picked up at period wrap so no period is truncated.
    assign larg_alvo = PW'(PWM_MIN) + PW'(STEP) * PW'(pos_q);

    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + PW'(1);
        pwm_larg_d = pwm_larg_q;
        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d  = '0;
            pwm_larg_d = larg_alvo;
        end
    end

    assign pwm = (pwm_cnt_q < pwm_larg_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q  <= '0;
            pwm_larg_q <= '0;
            echo_s1_q  <= 1'b0;
            echo_s2_q  <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_larg_q <= pwm_larg_d;
            echo_s1_q  <= echo;
            echo_s2_q  <= echo_s1_q;
        end
    end

    // One echo-high cycle of measurement; the rise cycle itself counts, starting from zero.
    always_comb begin
        sub_base  = (estado_q == StMede) ? sub_q : '0;
        dist_base = (estado_q == StMede) ? dist_q : '0;
        sub_inc   = sub_base + SW'(1);
        dist_inc  = dist_base;
        if (sub_base == SUB_LAST) begin
            sub_inc  = '0;
            dist_inc = (dist_base == DIST_MAX) ? dist_base : dist_base + DIST_W'(1);
        end
    end

    always_comb begin
        estado_d      = estado_q;
        cnt_d         = cnt_q;
        sub_d         = sub_q;
        dist_d        = dist_q;
        to_d          = to_q;
        pos_d         = pos_q;
        desce_d       = desce_q;
        modo_d        = modo_q;
        trigger       = 1'b0;
        valido        = 1'b0;
        fim_posicao   = 1'b0;
        fim_varredura = 1'b0;

        case (estado_q)
            StInicial: begin
                if (ligar) begin
                    modo_d   = modo;
                    cnt_d    = '0;
                    estado_d = StPosiciona;
                end
            end
            StPosiciona: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d    = '0;
                    estado_d = StDispara;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDispara: begin
                trigger = 1'b1;
                if (cnt_q == TRIG_LAST) begin
                    cnt_d    = '0;
                    estado_d = StEsperaEcho;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StEsperaEcho: begin
                if (echo_s2_q) begin
                    sub_d    = sub_inc;
                    dist_d   = dist_inc;
                    to_d     = 1'b0;
                    cnt_d    = '0;
                    estado_d = StMede;
                end else if (cnt_q == TO_LAST) begin
                    dist_d   = '1;
                    to_d     = 1'b1;
                    cnt_d    = '0;
                    estado_d = StEnvia;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StMede: begin
                if (!echo_s2_q) begin
                    to_d     = 1'b0;
                    cnt_d    = '0;
                    estado_d = StEnvia;
                end else if (cnt_q == TO_LAST) begin
                    dist_d   = '1;
                    to_d     = 1'b1;
                    cnt_d    = '0;
                    estado_d = StEnvia;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    sub_d  = sub_inc;
                    dist_d = dist_inc;
                end
            end
            StEnvia: begin
                valido = 1'b1;
                if (dado.dado_pronto) begin
                    fim_posicao = 1'b1;
                    estado_d    = StProxima;
                end
            end
            StProxima: begin
                if (!ligar) begin
                    pos_d    = '0;
                    desce_d  = 1'b0;
                    estado_d = StInicial;
                end else if (modo_q && pos_q == POS_LAST) begin
                    fim_varredura = 1'b1;
                    estado_d      = StFim;
                end else begin
                    cnt_d    = '0;
                    estado_d = StPosiciona;
                    if (!desce_q && pos_q == POS_LAST) begin
                        fim_varredura = 1'b1;
                        desce_d       = 1'b1;
                        pos_d         = pos_q - POS_W'(1);
                    end else if (desce_q && pos_q == '0) begin
                        fim_varredura = 1'b1;
                        desce_d       = 1'b0;
                        pos_d         = pos_q + POS_W'(1);
                    end else if (desce_q) begin
                        pos_d = pos_q - POS_W'(1);
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            StFim: begin
                if (!ligar) begin
                    pos_d    = '0;
                    desce_d  = 1'b0;
                    estado_d = StInicial;
                end
            end
            default: estado_d = StInicial;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= StInicial;
            cnt_q    <= '0;
            sub_q    <= '0;
            dist_q   <= '0;
            to_q     <= 1'b0;
            pos_q    <= '0;
            desce_q  <= 1'b0;
            modo_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            dist_q   <= dist_d;
            to_q     <= to_d;
            pos_q    <= pos_d;
            desce_q  <= desce_d;
            modo_q   <= modo_d;
        end
    end

    // Result fields come straight from registers that do not move while in StEnvia.
    assign dado.dado_valido    = valido;
    assign dado.dado_posicao   = pos_q;
    assign dado.dado_distancia = dist_q;
    assign dado.dado_timeout   = to_q;
    assign db_estado           = {1'b0, estado_q};

endmodule

// File: tb/tb_sonar_varredura.sv
// Bench for sonar_varredura: echo responder plus result scoreboard driven by a sweep model.
`timescale 1ns/1ps
module tb_sonar_varredura;

    localparam int unsigned NP     = 4;
    localparam int unsigned PER    = 1000;
    localparam int unsigned PMIN   = 100;
    localparam int unsigned PMAX   = 400;
    localparam int unsigned SETTLE = 50;
    localparam int unsigned TRIG   = 10;
    localparam int unsigned CPC    = 20;
    localparam int unsigned TMO    = 2000;
    localparam int unsigned DW     = 6;
    localparam int unsigned PWB    = 2;
    localparam int unsigned ECHO_DLY = 20;
    localparam int DMAX = (1 << DW) - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       modo  = 1'b0;
    logic       echo  = 1'b0;
    logic       trigger, pwm, fim_posicao, fim_varredura;
    logic [3:0] db_estado;

    sonar_varredura_if #(.POS_W(PWB), .DIST_W(DW)) dado_if ();

    sonar_varredura #(
        .N_POS(NP), .PWM_PERIOD(PER), .PWM_MIN(PMIN), .PWM_MAX(PMAX),
        .SETTLE_CYC(SETTLE), .TRIG_CYC(TRIG), .CYC_PER_CM(CPC),
        .TIMEOUT_CYC(TMO), .DIST_W(DW)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .modo(modo), .echo(echo),
        .trigger(trigger), .pwm(pwm), .dado(dado_if),
        .fim_posicao(fim_posicao), .fim_varredura(fim_varredura), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int len_q[$];
    int echo_len = 205;
    bit abort_echo = 1'b0;
    bit run_mode = 1'b0;
    int run_idx = 0;
    int xfers = 0;
    int fim_seen = 0;
    int last_pos = -1, last_dist = -1, last_to = -1;
    int tcnt = 0;
    int h_cur = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sweep model: position of the k-th result since ligar rose.
    function automatic int exp_pos(input int k, input bit m);
        int per;
        int p;
        per = 2 * (NP - 1);
        if (m) return k;
        p = k % per;
        return (p < int'(NP)) ? p : per - p;
    endfunction

    function automatic bit exp_to(input int h);
        return (h == 0) || (h > int'(TMO));
    endfunction

    function automatic int exp_dist(input int h);
        if (exp_to(h)) return DMAX;
        return (h / int'(CPC) > DMAX) ? DMAX : h / int'(CPC);
    endfunction

    function automatic int pwm_width(input int p);
        return int'(PMIN) + p * (int'(PMAX - PMIN) / int'(NP - 1));
    endfunction

    // Echo responder: after each trigger pulse, raise echo for the configured width.
    initial begin
        forever begin
            @(negedge clock); #1;
            if (!reset) tcnt = 0;
            else if (trigger) tcnt++;
            else if (tcnt > 0) begin
                check("trigger_width", tcnt, TRIG);
                tcnt  = 0;
                h_cur = echo_len;
                len_q.push_back(h_cur);
                if (h_cur > 0) begin
                    repeat (ECHO_DLY) @(negedge clock);
                    echo = 1'b1;
                    for (int i = 0; i < h_cur && !abort_echo; i++) @(negedge clock);
                    echo = 1'b0;
                end
            end
        end
    end

    // Compare process: handshake, hold stability, result contents, sweep-end pulses.
    bit prev_xfer = 1'b0, prev_hold = 1'b0;
    int prev_p = 0, prev_k = 0;
    logic [PWB-1:0] hp;
    logic [DW-1:0]  hd;
    logic           ht;
    initial begin
        int h, k, p;
        bit acc, ef;
        forever begin
            @(negedge clock); #1;
            if (!reset) begin
                prev_xfer = 1'b0;
                prev_hold = 1'b0;
                continue;
            end
            acc = dado_if.dado_valido && dado_if.dado_pronto;
            check("fim_posicao", fim_posicao, acc);
            if (fim_varredura) fim_seen++;
            if (prev_xfer) begin
                ef = ligar && ((prev_p == int'(NP) - 1) ||
                               (!run_mode && prev_p == 0 && prev_k > 0));
                check("fim_varredura_end", fim_varredura, ef);
            end else begin
                check("fim_varredura_idle", fim_varredura, 0);
            end
            if (prev_hold) begin
                check("hold_valido", dado_if.dado_valido, 1);
                check("hold_posicao", dado_if.dado_posicao, hp);
                check("hold_distancia", dado_if.dado_distancia, hd);
                check("hold_timeout", dado_if.dado_timeout, ht);
            end
            prev_xfer = 1'b0;
            if (acc) begin
                k = run_idx;
                p = exp_pos(k, run_mode);
                if (len_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL result_without_shot: got result, want none");
                    h = 0;
                end else begin
                    h = len_q.pop_front();
                end
                check("res_posicao", dado_if.dado_posicao, p);
                check("res_distancia", dado_if.dado_distancia, exp_dist(h));
                check("res_timeout", dado_if.dado_timeout, exp_to(h));
                last_pos  = dado_if.dado_posicao;
                last_dist = dado_if.dado_distancia;
                last_to   = dado_if.dado_timeout;
                prev_p    = p;
                prev_k    = k;
                prev_xfer = 1'b1;
                run_idx++;
                xfers++;
            end
            prev_hold = dado_if.dado_valido && !dado_if.dado_pronto;
            hp = dado_if.dado_posicao;
            hd = dado_if.dado_distancia;
            ht = dado_if.dado_timeout;
        end
    end

    task automatic wait_xfers(input int n, input int budget, input string name);
        int target;
        int c;
        target = xfers + n;
        c = 0;
        while (xfers < target && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(name, xfers >= target, 1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int c;
        c = 0;
        while (!dado_if.dado_valido && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(name, dado_if.dado_valido, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while (db_estado != 4'd0 && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(name, db_estado, 0);
    endtask

    task automatic measure_pwm(input string name, input int exp);
        int c;
        int h;
        c = 0;
        h = 0;
        @(negedge clock);
        while (pwm && c < 3000) begin @(negedge clock); c++; end
        while (!pwm && c < 3000) begin @(negedge clock); c++; end
        while (pwm && h < 3000) begin @(negedge clock); h++; end
        check(name, h, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_estado"}, db_estado, 0);
        check({tag, "_trigger"}, trigger, 0);
        check({tag, "_pwm"}, pwm, 0);
        check({tag, "_valido"}, dado_if.dado_valido, 0);
        check({tag, "_fim_pos"}, fim_posicao, 0);
        check({tag, "_fim_varr"}, fim_varredura, 0);
        check({tag, "_posicao"}, dado_if.dado_posicao, 0);
        check({tag, "_distancia"}, dado_if.dado_distancia, 0);
        check({tag, "_timeout"}, dado_if.dado_timeout, 0);
    endtask

    task automatic start_run(input bit m, input int len);
        run_mode = m;
        run_idx  = 0;
        modo     = m;
        echo_len = len;
        ligar    = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int c;
        dado_if.dado_pronto = 1'b0;
        repeat (3) @(negedge clock);
        #1 check_zero_outputs("reset");
        @(negedge clock);
        reset = 1'b1;
        measure_pwm("pwm_idle_pos0", pwm_width(0));

        // Single sweep, 205-cycle echoes, transmitter always ready.
        dado_if.dado_pronto = 1'b1;
        f0 = fim_seen;
        start_run(1'b1, 205);
        wait_xfers(4, 3000, "sweep1_results");
        repeat (5) @(negedge clock);
        check("sweep1_estado_fim", db_estado, 7);
        check("sweep1_fim_pulses", fim_seen - f0, 1);
        check("sweep1_last_pos", last_pos, 3);
        check("sweep1_last_dist", last_dist, 10);
        check("sweep1_last_to", last_to, 0);
        measure_pwm("pwm_fim_pos3", 400);
        ligar = 1'b0;
        wait_idle(10, "sweep1_back_idle");

        // Back-pressure: hold each result, measuring servo width while held.
        dado_if.dado_pronto = 1'b0;
        start_run(1'b1, 205);
        wait_valid(1000, "bp_valid0");
        repeat (40) @(negedge clock);
        dado_if.dado_pronto = 1'b1;
        @(negedge clock);
        dado_if.dado_pronto = 1'b0;
        wait_valid(1000, "bp_valid1");
        measure_pwm("pwm_pos1", 200);
        dado_if.dado_pronto = 1'b1;
        @(negedge clock);
        dado_if.dado_pronto = 1'b0;
        wait_valid(1000, "bp_valid2");
        measure_pwm("pwm_pos2", 300);
        dado_if.dado_pronto = 1'b1;
        wait_xfers(2, 1000, "bp_rest");
        repeat (3) @(negedge clock);
        ligar = 1'b0;
        wait_idle(10, "bp_back_idle");

        // Ping-pong: ten results, two sweep-end pulses before ligar drops.
        f0 = fim_seen;
        start_run(1'b0, 205);
        wait_xfers(10, 5000, "pingpong_results");
        ligar = 1'b0;
        wait_idle(20, "pingpong_idle");
        check("pingpong_fim_pulses", fim_seen - f0, 2);
        check("pingpong_last_pos", last_pos, 3);

        // Echo never rises, then echo stuck high for 3000 cycles.
        start_run(1'b0, 0);
        c = 0;
        while (!trigger && c < 500) begin @(negedge clock); c++; end
        while (trigger && c < 500) begin @(negedge clock); c++; end
        c = 0;
        while (!dado_if.dado_valido && c < 3000) begin @(negedge clock); c++; end
        check("timeout_latency_ok", (c >= 1990 && c <= 2010), 1);
        wait_xfers(1, 10, "timeout_xfer");
        check("norise_to", last_to, 1);
        check("norise_dist", last_dist, 63);
        dado_if.dado_pronto = 1'b0;
        echo_len = 3000;
        wait_valid(3000, "stuck_valid");
        repeat (1200) @(negedge clock);
        echo_len = 205;
        dado_if.dado_pronto = 1'b1;
        wait_xfers(1, 10, "stuck_xfer");
        check("stuck_to", last_to, 1);
        check("stuck_dist", last_dist, 63);
        wait_xfers(1, 1000, "after_timeout_xfer");
        check("after_timeout_pos", last_pos, 2);
        ligar = 1'b0;
        wait_idle(1000, "timeout_idle");

        // 2000-cycle echo: distance saturates without a timeout.
        start_run(1'b1, 2000);
        wait_xfers(1, 3000, "sat_xfer");
        ligar = 1'b0;
        check("sat_dist", last_dist, 63);
        check("sat_to", last_to, 0);
        wait_idle(20, "sat_idle");

        // Asynchronous reset in the middle of a measurement.
        start_run(1'b0, 205);
        c = 0;
        while (!echo && c < 500) begin @(negedge clock); c++; end
        repeat (40) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero_outputs("midreset");
        abort_echo = 1'b1;
        ligar = 1'b0;
        repeat (3) @(negedge clock);
        len_q.delete();
        abort_echo = 1'b0;
        reset = 1'b1;

        // ligar drops while positioning: the pending result still goes out.
        start_run(1'b0, 205);
        wait_xfers(1, 1000, "drop_first");
        repeat (10) @(negedge clock);
        ligar = 1'b0;
        wait_xfers(1, 1000, "drop_pending");
        check("drop_pending_pos", last_pos, 1);
        repeat (3) @(negedge clock);
        check("drop_estado", db_estado, 0);
        check("drop_posicao", dado_if.dado_posicao, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
